// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection on
// stall or branch flush, and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        ifid_rs,
    input  logic [4:0]        ifid_rt,
    input  logic [4:0]        ifid_rd,
    input  logic [9:0]        id_ctrl,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush_i,
    output logic [9:0]        idex_ctrl,
    output logic [DATA_W-1:0] idex_rs_data,
    output logic [DATA_W-1:0] idex_rt_data,
    output logic [DATA_W-1:0] idex_imm,
    output logic [DATA_W-1:0] idex_pc4,
    output logic [4:0]        idex_rs,
    output logic [4:0]        idex_rt,
    output logic [4:0]        idex_rd,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int            MEMREAD_BIT = 7;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    logic [9:0]        ctrl_q,    ctrl_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [DATA_W-1:0] pc4_q,     pc4_d;
    logic [4:0]        rs_q,      rs_d;
    logic [4:0]        rt_q,      rt_d;
    logic [4:0]        rd_q,      rd_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              hz;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // A load writing $zero never creates a real dependency.
    assign hz = ctrl_q[MEMREAD_BIT] && (rt_q != 5'd0) &&
                ((rt_q == ifid_rs) || (rt_q == ifid_rt));

    assign stall_o    = hz && !flush_i;
    assign pc_write   = !stall_o;
    assign ifid_write = !stall_o;

    always_comb begin
        ctrl_d      = id_ctrl;
        rs_data_d   = id_rs_data;
        rt_data_d   = id_rt_data;
        imm_d       = id_imm;
        pc4_d       = id_pc4;
        rs_d        = ifid_rs;
        rt_d        = ifid_rt;
        rd_d        = ifid_rd;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush_i || stall_o) begin
            // Bubble: zeroing rt also guarantees a stall never repeats.
            ctrl_d    = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            pc4_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            if (flush_i) flush_cnt_d = sat_inc(flush_cnt_q);
            else         stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q      <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            pc4_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            pc4_q       <= pc4_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign idex_ctrl    = ctrl_q;
    assign idex_rs_data = rs_data_q;
    assign idex_rt_data = rt_data_q;
    assign idex_imm     = imm_q;
    assign idex_pc4     = pc4_q;
    assign idex_rs      = rs_q;
    assign idex_rt      = rt_q;
    assign idex_rd      = rd_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: normal flow, load-use stalls, $zero rule,
// flush priority, counter saturation (CNT_W=2 instance) and async reset.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ifid_rs, ifid_rt, ifid_rd;
    logic [9:0]  id_ctrl;
    logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc4;
    logic        flush;

    logic [9:0]  idex_ctrl;
    logic [31:0] idex_rs_data, idex_rt_data, idex_imm, idex_pc4;
    logic [4:0]  idex_rs, idex_rt, idex_rd;
    logic        pc_write, ifid_write, stall;
    logic [15:0] stall_cnt, flush_cnt;

    logic [9:0]  s_ctrl;
    logic [31:0] s_rs_data, s_rt_data, s_imm, s_pc4;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic        s_pc_write, s_ifid_write, s_stall;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_rd(ifid_rd),
        .id_ctrl(id_ctrl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_pc4(id_pc4), .flush_i(flush),
        .idex_ctrl(idex_ctrl), .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data),
        .idex_imm(idex_imm), .idex_pc4(idex_pc4),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
        .pc_write(pc_write), .ifid_write(ifid_write), .stall_o(stall),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst_n),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_rd(ifid_rd),
        .id_ctrl(id_ctrl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_pc4(id_pc4), .flush_i(flush),
        .idex_ctrl(s_ctrl), .idex_rs_data(s_rs_data), .idex_rt_data(s_rt_data),
        .idex_imm(s_imm), .idex_pc4(s_pc4),
        .idex_rs(s_rs), .idex_rt(s_rt), .idex_rd(s_rd),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .stall_o(s_stall),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [31:0] pc4);
        id_ctrl    = c;
        ifid_rs    = rs;
        ifid_rt    = rt;
        ifid_rd    = rd;
        id_rs_data = rsd;
        id_rt_data = rtd;
        id_imm     = imm;
        id_pc4     = pc4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [9:0] LW  = 10'h390;
    localparam logic [9:0] ADD = 10'h208;

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        set_id(10'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        #12;
        check_eq("rst_ctrl", idex_ctrl, 10'h0);
        check_eq("rst_stall_cnt", stall_cnt, 16'd0);
        check_eq("rst_pc_write", pc_write, 1'b1);
        rst_n = 1'b1;
        tick();

        // Normal flow
        set_id(10'h2A5, 5'd1, 5'd3, 5'd9, 32'h12345678, 32'hCAFEF00D, 32'hFFFFFFF0, 32'h00400004);
        #1 check_eq("nf_no_stall", stall, 1'b0);
        tick();
        check_eq("nf_ctrl", idex_ctrl, 10'h2A5);
        check_eq("nf_rs_data", idex_rs_data, 32'h12345678);
        check_eq("nf_rt_data", idex_rt_data, 32'hCAFEF00D);
        check_eq("nf_imm", idex_imm, 32'hFFFFFFF0);
        check_eq("nf_pc4", idex_pc4, 32'h00400004);
        check_eq("nf_rd", idex_rd, 5'd9);
        check_eq("nf_rs", idex_rs, 5'd1);
        check_eq("nf_rt", idex_rt, 5'd3);

        // Load-use: lw $5 then consumer of $5
        set_id(LW, 5'd2, 5'd5, 5'd0, 32'h1000, 32'h0, 32'h8, 32'h00400008);
        #1 check_eq("lw_no_stall", stall, 1'b0);
        tick();
        check_eq("lw_ctrl", idex_ctrl, LW);
        check_eq("lw_rt", idex_rt, 5'd5);
        set_id(ADD, 5'd5, 5'd6, 5'd7, 32'h11, 32'h22, 32'h0, 32'h0040000C);
        #1;
        check_eq("lu_stall", stall, 1'b1);
        check_eq("lu_pc_write", pc_write, 1'b0);
        check_eq("lu_ifid_write", ifid_write, 1'b0);
        tick();
        check_eq("lu_bubble_ctrl", idex_ctrl, 10'h0);
        check_eq("lu_bubble_rt", idex_rt, 5'd0);
        check_eq("lu_bubble_rs_data", idex_rs_data, 32'h0);
        check_eq("lu_stall_cnt", stall_cnt, 16'd1);
        check_eq("sat_cnt_1", s_stall_cnt, 2'd1);
        check_eq("lu_stall_released", stall, 1'b0);
        tick();
        check_eq("lu_loaded_ctrl", idex_ctrl, ADD);
        check_eq("lu_loaded_rs", idex_rs, 5'd5);
        check_eq("lu_loaded_rd", idex_rd, 5'd7);

        // $zero rule
        set_id(LW, 5'd4, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        set_id(ADD, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 32'h0);
        #1 check_eq("zero_no_stall", stall, 1'b0);
        // lw $5 followed by an independent instruction
        set_id(LW, 5'd0, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        set_id(ADD, 5'd6, 5'd7, 5'd8, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h1234, 32'h00400020);
        #1 check_eq("indep_no_stall", stall, 1'b0);
        tick();
        check_eq("indep_ctrl", idex_ctrl, ADD);
        check_eq("indep_rs", idex_rs, 5'd6);
        check_eq("indep_rt", idex_rt, 5'd7);
        check_eq("indep_rs_data", idex_rs_data, 32'hA5A5A5A5);
        check_eq("indep_rt_data", idex_rt_data, 32'h5A5A5A5A);
        check_eq("indep_stall_cnt", stall_cnt, 16'd1);

        // Back-to-back dependent loads
        set_id(LW, 5'd1, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        set_id(LW, 5'd5, 5'd6, 5'd0, 32'h0, 32'h0, 32'h4, 32'h0);
        #1 check_eq("b2b_stall1", stall, 1'b1);
        tick();
        check_eq("b2b_stall_cnt2", stall_cnt, 16'd2);
        check_eq("sat_cnt_2", s_stall_cnt, 2'd2);
        tick();
        check_eq("b2b_lw2_ctrl", idex_ctrl, LW);
        check_eq("b2b_lw2_rt", idex_rt, 5'd6);
        set_id(ADD, 5'd6, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0);
        #1 check_eq("b2b_stall2", stall, 1'b1);
        tick();
        check_eq("b2b_stall_cnt3", stall_cnt, 16'd3);
        check_eq("sat_cnt_3", s_stall_cnt, 2'd3);
        tick();
        check_eq("b2b_add_ctrl", idex_ctrl, ADD);

        // Flush overrides stall
        set_id(LW, 5'd1, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        set_id(ADD, 5'd5, 5'd1, 5'd2, 32'h77, 32'h88, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        check_eq("fl_no_stall", stall, 1'b0);
        check_eq("fl_pc_write", pc_write, 1'b1);
        tick();
        flush = 1'b0;
        check_eq("fl_ctrl", idex_ctrl, 10'h0);
        check_eq("fl_rs_data", idex_rs_data, 32'h0);
        check_eq("fl_flush_cnt", flush_cnt, 16'd1);
        check_eq("fl_stall_cnt", stall_cnt, 16'd3);

        // Two more stalls: small counter must hold at 3
        for (int i = 0; i < 2; i++) begin
            set_id(LW, 5'd1, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
            tick();
            set_id(ADD, 5'd5, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 32'h0);
            tick();
            check_eq("sat_main_cnt", stall_cnt, 16'(4 + i));
            check_eq("sat_small_cnt", s_stall_cnt, 2'd3);
            tick();
        end

        // Asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_ctrl", idex_ctrl, 10'h0);
        check_eq("arst_rs_data", idex_rs_data, 32'h0);
        check_eq("arst_rt_data", idex_rt_data, 32'h0);
        check_eq("arst_imm", idex_imm, 32'h0);
        check_eq("arst_pc4", idex_pc4, 32'h0);
        check_eq("arst_rs", idex_rs, 5'd0);
        check_eq("arst_rt", idex_rt, 5'd0);
        check_eq("arst_rd", idex_rd, 5'd0);
        check_eq("arst_stall_cnt", stall_cnt, 16'd0);
        check_eq("arst_flush_cnt", flush_cnt, 16'd0);
        check_eq("arst_sat_cnt", s_stall_cnt, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS pipeline. Sits between decode and execute.
- Registers decoded control, operands and register addresses. Its idex_rs, idex_rt and idex_regw/regd fields drive the EX-stage forwarding unit and ALU muxes.
- Contains load-use hazard detection: freezes PC and IF/ID and injects a bubble. Branch flush also injects a bubble.
- Keeps saturating stall and flush performance counters.

Parameters:
- DATA_W, 32, datapath width of operands, immediate and PC.
- CNT_W, 16, width of stall_cnt and flush_cnt.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- ifid_rs  in  5  rs field of instruction in ID.
- ifid_rt  in  5  rt field of instruction in ID.
- ifid_rd  in  5  rd field of instruction in ID.
- id_ctrl  in  10  {regwrite, memtoreg, memread, memwrite, branch, alusrc, regdst, aluop[2:0]}.
- id_rs_data  in  DATA_W  register-file read port 1.
- id_rt_data  in  DATA_W  register-file read port 2.
- id_imm  in  DATA_W  sign-extended immediate.
- id_pc4  in  DATA_W  PC+4 of instruction in ID.
- flush_i  in  1  branch taken; squash instruction in ID.
- idex_ctrl  out  10  registered id_ctrl, same bit order.
- idex_rs_data, idex_rt_data, idex_imm, idex_pc4  out  DATA_W  registered data.
- idex_rs, idex_rt, idex_rd  out  5  registered register addresses.
- pc_write  out  1  0 = hold PC (combinational).
- ifid_write  out  1  0 = hold IF/ID (combinational).
- stall_o  out  1  1 = load-use stall this cycle (combinational).
- stall_cnt  out  CNT_W  bubbles inserted due to load-use.
- flush_cnt  out  CNT_W  bubbles inserted due to flush.

Behaviour:
- Reset (rst_i=0, async):
  - All registered outputs go to 0, including idex_ctrl=0, which is a NOP.
  - stall_cnt=0, flush_cnt=0.
  - Reset holds while low, independent of clk_i.
- Hazard detect (combinational): hz = idex_ctrl.memread && idex_rt!=0 && (idex_rt==ifid_rs || idex_rt==ifid_rt).
  - stall_o = hz && !flush_i.
  - pc_write = ifid_write = !stall_o.
- Per rising edge, priority is reset > flush > stall > load:
  - flush_i=1: idex_ctrl<=0; data and address fields <=0; flush_cnt++ (saturating).
  - else stall_o=1: idex_ctrl<=0 (bubble); data and address fields <=0; stall_cnt++ (saturating).
  - else: all idex_* fields <= corresponding ID inputs.
- Bubble clears idex_rt to 0, so a stall lasts exactly 1 cycle per load-use pair. The re-evaluated instruction in ID then proceeds; the load result is forwarded from MEM/WB.
- A flush overrides a simultaneous stall. Only flush_cnt increments, and pc_write stays 1.
- Back-to-back loads each cause an independent 1-cycle stall when dependent.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Latency: 1 cycle, ID to EX. No internal state beyond the pipeline register and counters.
- $zero rule: idex_rt==0 never stalls, even with memread=1.

Test Plan:
- Reset: drive rst_i=0 mid-operation with non-zero state and no clk edge → all outputs 0 immediately, including the counters.
- Load-use: lw $5 in EX (memread=1, idex_rt=5), ID has ifid_rs=5 →
  - stall_o=1, pc_write=0, ifid_write=0.
  - Next edge: idex_ctrl=0, stall_cnt=1.
  - Following edge: ID instruction is loaded and stall_o=0.
- No false stall:
  - lw to $0 (idex_rt=0) with ifid_rs=0 → stall_o=0.
  - lw $5 with ifid_rs=6, ifid_rt=7 → no stall; fields are loaded unchanged.
- Flush vs stall: load-use condition with flush_i=1 → stall_o=0, pc_write=1, idex_ctrl=0, flush_cnt=1, stall_cnt unchanged.
- Normal flow: id_ctrl=10'h2A5, id_rs_data=32'h12345678, ifid_rd=9 → after one edge the outputs equal these values.
- Saturation: CNT_W=2, force 5 load-use stalls → stall_cnt sequence 1,2,3,3,3.
